instr_fetch_unit: RTL

- Produces the instruction stream that the control unit decodes.
- Owns the program counter and issues word fetches to instruction memory over a read/busywait handshake.
- Latches each 32-bit instruction and splits it into OP, destination/offset, source and immediate fields.
- Consumes the control unit's jump/beq outputs and the ALU zero flag to select the next PC.

---
 rtl/instr_fetch_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a read/busywait
// handshake, latches the instruction fields and resolves jump/beq targets.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  JUMP,
  input  logic                  BEQ,
  input  logic                  ZERO,
  input  logic                  STALL,
  output logic                  IMEM_READ,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic                  IMEM_BUSYWAIT,
  input  logic [31:0]           IMEM_INSTR,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  INSTR_VALID,
  output logic [7:0]            OP,
  output logic [7:0]            DEST,
  output logic [7:0]            SRC1,
  output logic [7:0]            SRC2_IMM
);

  localparam int unsigned           OFF_W = 8;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] seq_pc_c;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic                  taken_c;
  logic                  latch_c;

  // Next state, next PC and instruction-latch strobe.
  always_comb begin
    state_d  = state_q;
    pc_d     = PC;
    latch_c  = 1'b0;
    taken_c  = JUMP | (BEQ & ZERO);
    seq_pc_c = PC + STEP;
    // DEST is a signed word offset; scale it to bytes, wrapping naturally.
    offset_c = {{(ADDR_WIDTH - OFF_W){DEST[OFF_W-1]}}, DEST} * STEP;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          state_d = EXEC;
          latch_c = 1'b1;
        end
      end
      EXEC: begin
        if (!STALL) begin
          state_d = FETCH;
          pc_d    = taken_c ? (seq_pc_c + offset_c) : seq_pc_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, fields and Moore outputs, all registered.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      PC          <= PC_RESET;
      IMEM_READ   <= 1'b0;
      INSTR_VALID <= 1'b0;
      OP          <= '0;
      DEST        <= '0;
      SRC1        <= '0;
      SRC2_IMM    <= '0;
    end else begin
      state_q     <= state_d;
      PC          <= pc_d;
      IMEM_READ   <= (state_d == FETCH);
      INSTR_VALID <= (state_d == EXEC);
      if (latch_c) begin
        {OP, DEST, SRC1, SRC2_IMM} <= IMEM_INSTR;
      end
    end
  end

  assign IMEM_ADDR = PC;

endmodule
